wb_write_buffer: RTL and testbench

- Posted-write line buffer between the L2 arbiter's master port (upstream) and the L2 cache slave port (downstream).
- Upstream line writes are acknowledged as soon as they are buffered; buffered entries then drain to L2 in FIFO order.
- Writes to a line already buffered are merged byte-wise. A read to a buffered line is held until that line has drained, so a read never returns stale data.

---
 rtl/wb_write_buffer_if.sv | 28 ++
 rtl/wb_write_buffer.sv | 151 +++++++++++++++
 tb/tb_wb_write_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_buffer_if.sv
// Wishbone line-transfer bundle shared by the upstream (arbiter) and
// downstream (L2) sides of the posted-write buffer.
interface wb_write_buffer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] dat_m;
  logic [DATA_W-1:0] dat_s;
  logic              ack;
  logic              rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, rty
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Posted-write line buffer between the L2 arbiter and the L2 cache.
// Writes are acknowledged once buffered (merging byte-wise into a pending
// entry for the same line), then drained to L2 in FIFO order. Reads to a
// buffered line wait until that line has drained.
module wb_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_write_buffer_if.slave  s,
  wb_write_buffer_if.master m,
  output logic              empty
);
  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] adr_q  [DEPTH];
  logic [SEL_W-1:0]  sel_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              ack_q, rty_q, empty_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req, wr_req, rd_req, full;
  logic [DEPTH-1:0]  match;
  logic              merge_hit;
  logic [PTR_W-1:0]  merge_idx;
  logic              do_merge, do_alloc, drain_ack, read_ack, read_rty;

  // Request qualification and address match against the registered entries.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    req       = s.cyc & s.stb & ~ack_q & ~rty_q;
    wr_req    = req & s.we;
    rd_req    = req & ~s.we;
    full      = (count_q == (PTR_W+1)'(DEPTH));
    match     = '0;
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (adr_q[i] == s.adr);
      // The head being driven to L2 must stay stable, so it is not mergeable.
      if (match[i] && !(state_q == DRAIN && PTR_W'(i) == head_q)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
    do_merge  = wr_req & merge_hit;
    do_alloc  = wr_req & ~merge_hit & ~full;
    drain_ack = (state_q == DRAIN) & m.ack;
    read_ack  = (state_q == READ) & m.ack;
    read_rty  = (state_q == READ) & m.rty & ~m.ack;
    count_d   = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(drain_ack);
  end

  // Downstream FSM: next state and L2 request signals.
  always_comb begin
    state_d = state_q;
    m.cyc   = 1'b0;
    m.stb   = 1'b0;
    m.we    = 1'b0;
    m.adr   = '0;
    m.sel   = '0;
    m.dat_m = '0;
    unique case (state_q)
      IDLE: begin
        if (rd_req && match == '0) state_d = READ;
        else if (count_q != '0)    state_d = DRAIN;
      end
      DRAIN: begin
        m.cyc   = 1'b1;
        m.stb   = 1'b1;
        m.we    = 1'b1;
        m.adr   = adr_q[head_q];
        m.sel   = sel_q[head_q];
        m.dat_m = data_q[head_q];
        // A retry returns through IDLE, dropping cyc/stb for one cycle.
        if (m.ack || m.rty) state_d = IDLE;
      end
      READ: begin
        m.cyc = 1'b1;
        m.stb = 1'b1;
        m.adr = s.adr;
        m.sel = s.sel;
        if (m.ack || m.rty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, pointers, valid bits and upstream responses.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdata_q <= '0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      ack_q   <= do_merge | do_alloc | read_ack;
      rty_q   <= read_rty;
      if (read_ack) rdata_q <= m.dat_s;
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (drain_ack) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
    end
  end

  // Entry payload: allocate at the tail or merge selected bytes into a match.
  // NOTE: payload storage has no reset; valid_q alone decides whether an
  // entry's contents mean anything.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      adr_q[tail_q]  <= s.adr;
      sel_q[tail_q]  <= s.sel;
      data_q[tail_q] <= s.dat_m;
    end else if (do_merge) begin
      sel_q[merge_idx] <= sel_q[merge_idx] | s.sel;
      for (int b = 0; b < SEL_W; b++) begin
        if (s.sel[b]) data_q[merge_idx][8*b +: 8] <= s.dat_m[8*b +: 8];
      end
    end
  end

  assign s.ack   = ack_q;
  assign s.rty   = rty_q;
  assign s.dat_s = rdata_q;
  assign empty   = empty_q;
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: stimulus pushes expected L2 transfers
// and upstream responses into queues; a monitor pops and compares them.
module tb_wb_write_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic empty;

  always #5 clk = ~clk;

  wb_write_buffer_if #(.ADDR_W(12), .DATA_W(128)) s_if ();
  wb_write_buffer_if #(.ADDR_W(12), .DATA_W(128)) m_if ();

  wb_write_buffer #(.DEPTH(4), .ADDR_W(12), .DATA_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s_if),
    .m     (m_if),
    .empty (empty)
  );

  typedef struct packed {
    logic         we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] data;
  } m_txn_t;

  typedef struct packed {
    logic         rty;
    logic         chk_data;
    logic [127:0] data;
  } s_rsp_t;

  m_txn_t exp_m[$];
  s_rsp_t exp_s[$];

  int checks = 0;
  int errors = 0;

  // L2 model controls
  logic         l2_stall = 1'b0;
  int           l2_delay = 0;
  int           l2_rty_cnt = 0;
  logic [127:0] l2_rdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] d);
    m_txn_t t;
    t.we = 1'b1; t.adr = adr; t.sel = sel; t.data = d;
    exp_m.push_back(t);
  endtask

  task automatic exp_rd(input logic [11:0] adr, input logic [15:0] sel);
    m_txn_t t;
    t.we = 1'b0; t.adr = adr; t.sel = sel; t.data = '0;
    exp_m.push_back(t);
  endtask

  task automatic exp_rsp(input logic rty, input logic chk, input logic [127:0] d);
    s_rsp_t r;
    r.rty = rty; r.chk_data = chk; r.data = d;
    exp_s.push_back(r);
  endtask

  // L2 responder: ack (or retry) l2_delay cycles after a request appears.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    m_if.ack = 1'b0;
    m_if.rty = 1'b0;
    m_if.dat_s = '0;
    forever begin
      @(negedge clk);
      m_if.ack = 1'b0;
      m_if.rty = 1'b0;
      if (rst_n && m_if.cyc && m_if.stb && !l2_stall) begin
        if (wait_cnt >= l2_delay) begin
          wait_cnt = 0;
          if (l2_rty_cnt > 0) begin
            m_if.rty = 1'b1;
            l2_rty_cnt--;
          end else begin
            m_if.ack = 1'b1;
            m_if.dat_s = l2_rdata;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare completed L2 transfers and upstream responses in order.
  initial begin
    m_txn_t e;
    s_rsp_t r;
    logic [127:0] mask;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && m_if.cyc && m_if.stb && m_if.ack) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_unexpected adr=%h we=%b", m_if.adr, m_if.we);
        end else begin
          e = exp_m.pop_front();
          check("m_we", m_if.we, e.we);
          check("m_adr", m_if.adr, e.adr);
          check("m_sel", m_if.sel, e.sel);
          if (e.we) begin
            mask = '0;
            for (int b = 0; b < 16; b++) if (e.sel[b]) mask[8*b +: 8] = 8'hFF;
            check("m_dat", m_if.dat_m & mask, e.data & mask);
          end
        end
      end
      if (rst_n && (s_if.ack || s_if.rty)) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected ack=%b rty=%b", s_if.ack, s_if.rty);
        end else begin
          r = exp_s.pop_front();
          check("s_rty", s_if.rty, r.rty);
          check("s_ack", s_if.ack, !r.rty);
          if (r.chk_data) check("s_dat", s_if.dat_s, r.data);
        end
      end
    end
  end

  // Issue one upstream request and wait (bounded) for ack or retry; the
  // request stays driven on return.
  task automatic wb_req(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                        input logic [127:0] d, input int max_cyc,
                        output int n, output logic got_ack, output logic got_rty);
    @(negedge clk);
    s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = we;
    s_if.adr = adr; s_if.sel = sel; s_if.dat_m = d;
    n = 0; got_ack = 1'b0; got_rty = 1'b0;
    while (n < max_cyc && !got_ack && !got_rty) begin
      @(posedge clk); #1;
      n++;
      got_ack = s_if.ack;
      got_rty = s_if.rty;
    end
  endtask

  task automatic wb_idle();
    @(negedge clk);
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (empty && !m_if.cyc) break;
    end
    check(name, empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic ga, gr, seen;
    logic [127:0] a_d, b_d, c_d, d_d, e_d, x_d, r1, r2;
    a_d = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    b_d = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    c_d = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    d_d = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    e_d = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
    x_d = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    r1  = 128'h11112222_33334444_55556666_77778888;
    r2  = 128'h99990000_AAAA1111_BBBB2222_CCCC3333;

    rst_n = 1'b0;
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    s_if.adr = '0; s_if.sel = '0; s_if.dat_m = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_cyc", m_if.cyc, 1'b0);
    check("rst_m_adr", m_if.adr, 12'h000);
    check("rst_s_ack", s_if.ack, 1'b0);
    check("rst_empty", empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic posted write, L2 acks 2 cycles after m_stb.
    l2_delay = 2;
    exp_rsp(1'b0, 1'b0, '0);
    exp_wr(12'h010, 16'hFFFF, a_d);
    wb_req(1'b1, 12'h010, 16'hFFFF, a_d, 5, n, ga, gr);
    check("wr_ack", ga, 1'b1);
    check("wr_lat", n, 1);
    check("wr_not_empty", empty, 1'b0);
    wb_idle();
    wait_empty("wr_drained", 20);

    // Merge behind a stalled head; a write to the in-flight head allocates.
    l2_stall = 1'b1;
    l2_delay = 0;
    repeat (4) exp_rsp(1'b0, 1'b0, '0);
    exp_wr(12'h0FF, 16'hFFFF, x_d);
    exp_wr(12'h020, 16'hFFFF, 128'hC0C1C2C3_C4C5C6C7_B8B9BABB_BCBDBEBF);
    exp_wr(12'h0FF, 16'h0001, e_d);
    wb_req(1'b1, 12'h0FF, 16'hFFFF, x_d, 5, n, ga, gr);
    check("mrg_ack0", ga, 1'b1);
    wb_req(1'b1, 12'h020, 16'h00FF, b_d, 5, n, ga, gr);
    check("mrg_ack1", ga, 1'b1);
    wb_req(1'b1, 12'h020, 16'hFF00, c_d, 5, n, ga, gr);
    check("mrg_ack2", ga, 1'b1);
    wb_req(1'b1, 12'h0FF, 16'h0001, e_d, 5, n, ga, gr);
    check("mrg_ack3", ga, 1'b1);
    wb_idle();
    check("mrg_head_adr", m_if.adr, 12'h0FF);
    l2_stall = 1'b0;
    wait_empty("mrg_drained", 30);

    // Full buffer: 4 writes accepted, 5th stalls until the first drain.
    l2_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_rsp(1'b0, 1'b0, '0);
      exp_wr(12'(i), 16'hFFFF, {32{4'(i)}});
    end
    for (int i = 1; i <= 4; i++) begin
      wb_req(1'b1, 12'(i), 16'hFFFF, {32{4'(i)}}, 4, n, ga, gr);
      check("full_fill_ack", ga, 1'b1);
    end
    wb_req(1'b1, 12'h005, 16'hFFFF, {32{4'd5}}, 6, n, ga, gr);
    check("full_stall_ack", ga, 1'b0);
    check("full_stall_rty", gr, 1'b0);
    l2_stall = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 10 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = s_if.ack;
    end
    check("full_late_ack", seen, 1'b1);
    check("full_late_lat", n, 2);
    wb_idle();
    wait_empty("full_drained", 40);

    // Read to a buffered line waits for its drain.
    l2_stall = 1'b1;
    l2_delay = 1;
    l2_rdata = r1;
    exp_rsp(1'b0, 1'b0, '0);
    exp_rsp(1'b0, 1'b1, r1);
    exp_wr(12'h030, 16'hFFFF, d_d);
    exp_rd(12'h030, 16'hFFFF);
    wb_req(1'b1, 12'h030, 16'hFFFF, d_d, 5, n, ga, gr);
    check("raw_wr_ack", ga, 1'b1);
    fork
      wb_req(1'b0, 12'h030, 16'hFFFF, '0, 40, n, ga, gr);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("raw_hold_we", m_if.we, 1'b1);
        check("raw_hold_adr", m_if.adr, 12'h030);
        l2_stall = 1'b0;
      end
    join
    check("raw_rd_ack", ga, 1'b1);
    check("raw_rd_dat", s_if.dat_s, r1);
    wb_idle();
    @(posedge clk); #1;
    check("raw_ack_once", s_if.ack, 1'b0);

    // Read miss on empty buffer: m_stb next cycle, s_ack one cycle after m_ack.
    l2_delay = 0;
    l2_rdata = r2;
    exp_rsp(1'b0, 1'b1, r2);
    exp_rd(12'h050, 16'hF0F0);
    wb_req(1'b0, 12'h050, 16'hF0F0, '0, 10, n, ga, gr);
    check("rdm_ack", ga, 1'b1);
    check("rdm_lat", n, 2);
    check("rdm_dat", s_if.dat_s, r2);
    wb_idle();

    // Retry on the first drain attempt: cyc drops one cycle, same entry reissued.
    l2_rty_cnt = 1;
    exp_rsp(1'b0, 1'b0, '0);
    exp_wr(12'h040, 16'hFFFF, c_d);
    wb_req(1'b1, 12'h040, 16'hFFFF, c_d, 5, n, ga, gr);
    check("drty_wr_ack", ga, 1'b1);
    wb_idle();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #2;
      seen = m_if.cyc & m_if.rty;
    end
    check("drty_seen", seen, 1'b1);
    @(posedge clk); #1;
    check("drty_cyc_drop", m_if.cyc, 1'b0);
    check("drty_no_srty", s_if.rty, 1'b0);
    @(posedge clk); #1;
    check("drty_reissue_cyc", m_if.cyc, 1'b1);
    check("drty_reissue_adr", m_if.adr, 12'h040);
    wait_empty("drty_drained", 20);

    // Retry during a read: one s_rty pulse, no s_ack, read data held.
    l2_rty_cnt = 1;
    exp_rsp(1'b1, 1'b0, '0);
    wb_req(1'b0, 12'h060, 16'hFFFF, '0, 10, n, ga, gr);
    check("rrty_rty", gr, 1'b1);
    check("rrty_ack", ga, 1'b0);
    check("rrty_dat_hold", s_if.dat_s, r2);
    wb_idle();
    @(posedge clk); #1;
    check("rrty_once", s_if.rty, 1'b0);
    check("rrty_no_ack", s_if.ack, 1'b0);

    // Asynchronous reset while draining.
    l2_stall = 1'b1;
    exp_rsp(1'b0, 1'b0, '0);
    wb_req(1'b1, 12'h070, 16'hFFFF, a_d, 5, n, ga, gr);
    wb_idle();
    repeat (2) @(posedge clk);
    #3;
    check("arst_pre_stb", m_if.stb, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_m_stb", m_if.stb, 1'b0);
    check("arst_m_cyc", m_if.cyc, 1'b0);
    check("arst_m_we", m_if.we, 1'b0);
    check("arst_m_adr", m_if.adr, 12'h000);
    check("arst_s_dat", s_if.dat_s, 128'h0);
    check("arst_empty", empty, 1'b1);
    l2_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | m_if.cyc;
    end
    check("arst_quiet", seen, 1'b0);

    check("exp_m_left", exp_m.size(), 0);
    check("exp_s_left", exp_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
